// File: rtl/tlb_op_ctrl.sv
// TLB maintenance op sequencer (TLBP/TLBR/TLBWI/TLBWR) between WB, CP0 and the TLB array.
// Define TLBWR_RANDOM_EN to make TLBWR write at a free-running random index instead of Index.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            op_valid,
    input  logic [1:0]      op_type,
    output logic            op_ready,
    input  logic            ex_flush,
    input  logic            cp0_wr_busy,
    input  logic [31:0]     cp0_entryhi,
    input  logic [31:0]     cp0_entrylo0,
    input  logic [31:0]     cp0_entrylo1,
    input  logic [31:0]     cp0_index,
    output logic [18:0]     s1_vpn2,
    output logic [7:0]      s1_asid,
    input  logic            s1_found,
    input  logic [IDXW-1:0] s1_index,
    output logic [IDXW-1:0] r_index,
    output logic            we,
    output logic [IDXW-1:0] w_index,
    output logic [18:0]     w_vpn2,
    output logic [7:0]      w_asid,
    output logic            w_g,
    output logic [19:0]     w_pfn0,
    output logic [2:0]      w_c0,
    output logic            w_d0,
    output logic            w_v0,
    output logic [19:0]     w_pfn1,
    output logic [2:0]      w_c1,
    output logic            w_d1,
    output logic            w_v1,
    output logic            cp0_tlbp,
    output logic            cp0_tlbp_found,
    output logic [IDXW-1:0] cp0_index_out,
    output logic            cp0_tlbr,
    output logic            done,
    output logic            refetch
);
    typedef enum logic [1:0] {IDLE, CHECK, EXEC, COMMIT} state_t;

    localparam logic [1:0] OP_TLBP = 2'b00;
    localparam logic [1:0] OP_TLBR = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    state_t          state, state_nx;
    logic [1:0]      op_q;
    logic [18:0]     vpn2_q;
    logic [7:0]      asid_q;
    logic [25:0]     lo0_q, lo1_q;
    logic [IDXW-1:0] idx_q, widx_q, widx_nx;
    logic            found_q;
    logic [IDXW-1:0] fidx_q;
    logic            accept, snap, commit;
    logic [1:0]      op_sel;

    logic unused_ok;
    assign unused_ok = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26],
                         cp0_index[31:IDXW], 1'(TLBNUM == (1 << IDXW))};

    assign accept = (state == IDLE) && op_valid && !ex_flush;
    // The accept cycle doubles as the first CHECK cycle, so an unblocked op reaches EXEC next cycle.
    assign op_sel = (state == IDLE) ? op_type : op_q;

`ifdef TLBWR_RANDOM_EN
    logic [IDXW-1:0] rand_idx;

    // Wraps TLBNUM-1 -> 0 -> TLBNUM-1 for free since TLBNUM == 1<<IDXW.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rand_idx <= IDXW'(TLBNUM - 1);
        else         rand_idx <= rand_idx - 1'b1;
    end

    assign widx_nx = (op_sel == OP_TLBWR) ? rand_idx : cp0_index[IDXW-1:0];
`else
    logic unused_op;
    assign unused_op = ^op_sel;
    assign widx_nx   = cp0_index[IDXW-1:0];
`endif

    always_comb begin
        state_nx = state;
        snap     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cp0_wr_busy) state_nx = CHECK;
                    else begin
                        snap     = 1'b1;
                        state_nx = EXEC;
                    end
                end
            end
            CHECK: begin
                if (ex_flush) state_nx = IDLE;
                else if (!cp0_wr_busy) begin
                    snap     = 1'b1;
                    state_nx = EXEC;
                end
            end
            EXEC:    state_nx = ex_flush ? IDLE : COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            op_q    <= 2'b00;
            vpn2_q  <= '0;
            asid_q  <= '0;
            lo0_q   <= '0;
            lo1_q   <= '0;
            idx_q   <= '0;
            widx_q  <= '0;
            found_q <= 1'b0;
            fidx_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) op_q <= op_type;
            if (snap) begin
                vpn2_q <= cp0_entryhi[31:13];
                asid_q <= cp0_entryhi[7:0];
                lo0_q  <= cp0_entrylo0[25:0];
                lo1_q  <= cp0_entrylo1[25:0];
                idx_q  <= cp0_index[IDXW-1:0];
                widx_q <= widx_nx;
            end
            if (state == EXEC) begin
                found_q <= s1_found;
                fidx_q  <= s1_index;
            end
        end
    end

    assign commit   = (state == COMMIT);
    assign op_ready = (state == IDLE);

    assign s1_vpn2 = vpn2_q;
    assign s1_asid = asid_q;
    assign r_index = idx_q;

    assign w_index = widx_q;
    assign w_vpn2  = vpn2_q;
    assign w_asid  = asid_q;
    assign w_g     = lo0_q[0] & lo1_q[0];
    assign w_pfn0  = lo0_q[25:6];
    assign w_c0    = lo0_q[5:3];
    assign w_d0    = lo0_q[2];
    assign w_v0    = lo0_q[1];
    assign w_pfn1  = lo1_q[25:6];
    assign w_c1    = lo1_q[5:3];
    assign w_d1    = lo1_q[2];
    assign w_v1    = lo1_q[1];

    assign we             = commit && op_q[1];
    assign cp0_tlbp       = commit && (op_q == OP_TLBP);
    assign cp0_tlbp_found = cp0_tlbp && found_q;
    assign cp0_index_out  = fidx_q;
    assign cp0_tlbr       = commit && (op_q == OP_TLBR);
    assign done           = commit;
    assign refetch        = commit && (op_q != OP_TLBP);
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Randomized bench for tlb_op_ctrl with a cycle-level reference of op timing and commit results.
// Compile with the same TLBWR_RANDOM_EN setting as the RTL.
module tb_tlb_op_ctrl;
    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic            op_valid, op_ready, ex_flush, cp0_wr_busy;
    logic [1:0]      op_type;
    logic [31:0]     cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index;
    logic [18:0]     s1_vpn2, w_vpn2;
    logic [7:0]      s1_asid, w_asid;
    logic            s1_found, we, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [IDXW-1:0] s1_index, r_index, w_index, cp0_index_out;
    logic [19:0]     w_pfn0, w_pfn1;
    logic [2:0]      w_c0, w_c1;
    logic            cp0_tlbp, cp0_tlbp_found, cp0_tlbr, done, refetch;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, rst_cyc = 0;
    logic [IDXW-1:0] last_w;

    tlb_op_ctrl #(.TLBNUM(TLBNUM), .IDXW(IDXW)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_type(op_type), .op_ready(op_ready),
        .ex_flush(ex_flush), .cp0_wr_busy(cp0_wr_busy), .cp0_entryhi(cp0_entryhi),
        .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1), .cp0_index(cp0_index),
        .s1_vpn2(s1_vpn2), .s1_asid(s1_asid), .s1_found(s1_found), .s1_index(s1_index),
        .r_index(r_index), .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .cp0_tlbp(cp0_tlbp), .cp0_tlbp_found(cp0_tlbp_found), .cp0_index_out(cp0_index_out),
        .cp0_tlbr(cp0_tlbr), .done(done), .refetch(refetch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic idle_cycle();
        op_valid = 1'b0; ex_flush = 1'b0; cp0_wr_busy = 1'b0;
        @(posedge clk); #1;
    endtask

    // Runs one op starting at posedge+1. nbusy = cycles of cp0_wr_busy from accept,
    // fl = cycle (relative to accept) carrying ex_flush, -1 for none.
    task automatic run_op(input int op, input int nbusy, input int fl, input bit fix,
                          input logic [31:0] fhi, input logic [31:0] flo0, input logic [31:0] flo1,
                          input logic [31:0] fidx, input bit ffound, input int fsidx);
        logic [31:0] shi = 0, slo0 = 0, slo1 = 0, sidx = 0;
        logic sf = 0;
        logic [IDXW-1:0] ssi = 0, expw;
        int snapc = 0;
        bit acc, ab, cm;
        int active_end;
        acc = (fl != 0);
        ab = acc && fl >= 1 && fl <= nbusy + 1;
        active_end = ab ? fl : nbusy + 2;
        for (int c = 0; c <= nbusy + 3; c++) begin
            op_valid = (c == 0);
            op_type = 2'(op);
            cp0_wr_busy = (c < nbusy);
            ex_flush = (c == fl);
            cp0_entryhi = $urandom; cp0_entrylo0 = $urandom;
            cp0_entrylo1 = $urandom; cp0_index = $urandom;
            s1_found = 1'($urandom); s1_index = IDXW'($urandom);
            if (fix && c == nbusy) begin
                cp0_entryhi = fhi; cp0_entrylo0 = flo0; cp0_entrylo1 = flo1; cp0_index = fidx;
            end
            if (fix && c == nbusy + 1) begin
                s1_found = ffound; s1_index = IDXW'(fsidx);
            end
            if (c == nbusy) begin
                shi = cp0_entryhi; slo0 = cp0_entrylo0; slo1 = cp0_entrylo1; sidx = cp0_index;
                snapc = cyc;
            end
            if (c == nbusy + 1) begin
                sf = s1_found; ssi = s1_index;
            end
            @(negedge clk);
            cm = acc && !ab && (c == nbusy + 2);
            chk("op_ready", op_ready, !acc || c == 0 || c > active_end);
            chk("done", done, cm);
            chk("we", we, cm && op >= 2);
            chk("cp0_tlbp", cp0_tlbp, cm && op == 0);
            chk("tlbp_found", cp0_tlbp_found, cm && op == 0 && sf);
            chk("cp0_tlbr", cp0_tlbr, cm && op == 1);
            chk("refetch", refetch, cm && op != 0);
            if (acc && c == nbusy + 1 && !(ab && fl <= nbusy)) begin
                chk("s1_vpn2", s1_vpn2, shi >> 13);
                chk("s1_asid", s1_asid, shi & 32'hff);
                chk("r_index_exec", r_index, sidx % TLBNUM);
            end
            if (cm && op == 0) chk("cp0_index_out", cp0_index_out, ssi);
            if (cm && op == 1) chk("r_index_commit", r_index, sidx % TLBNUM);
            if (cm && op >= 2) begin
                expw = IDXW'(sidx % TLBNUM);
`ifdef TLBWR_RANDOM_EN
                if (op == 3) expw = IDXW'((TLBNUM - 1 - (snapc - rst_cyc)) & (TLBNUM - 1));
`endif
                last_w = w_index;
                chk("w_index", w_index, expw);
                chk("w_vpn2", w_vpn2, shi >> 13);
                chk("w_asid", w_asid, shi & 32'hff);
                chk("w_g", w_g, slo0 & slo1 & 1);
                chk("w_pfn0", w_pfn0, (slo0 >> 6) & 32'hfffff);
                chk("w_c0", w_c0, (slo0 >> 3) & 7);
                chk("w_d0", w_d0, (slo0 >> 2) & 1);
                chk("w_v0", w_v0, (slo0 >> 1) & 1);
                chk("w_pfn1", w_pfn1, (slo1 >> 6) & 32'hfffff);
                chk("w_c1", w_c1, (slo1 >> 3) & 7);
                chk("w_d1", w_d1, (slo1 >> 2) & 1);
                chk("w_v1", w_v1, (slo1 >> 1) & 1);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [IDXW-1:0] w1;
        int nb, f;
        resetn = 1'b0; op_valid = 1'b0; op_type = 2'b00; ex_flush = 1'b0; cp0_wr_busy = 1'b0;
        cp0_entryhi = 0; cp0_entrylo0 = 0; cp0_entrylo1 = 0; cp0_index = 0;
        s1_found = 1'b0; s1_index = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_op_ready", op_ready, 1);
        chk("rst_we", we, 0);
        chk("rst_done", done, 0);
        chk("rst_refetch", refetch, 0);
        chk("rst_tlbp", {cp0_tlbp, cp0_tlbp_found, cp0_tlbr}, 0);
        chk("rst_snap", {s1_vpn2, s1_asid, w_index, r_index}, 0);
        @(posedge clk); #1;
        resetn = 1'b1; rst_cyc = cyc;

        // TLBP hit / miss, TLBWI field decode, TLBR
        run_op(0, 0, -1, 1, 32'h0040_2005, 0, 0, 0, 1, 7);
        run_op(0, 0, -1, 1, 32'h0040_2005, 0, 0, 0, 0, 7);
        run_op(2, 0, -1, 1, $urandom, 32'h0000_1047, 32'h0000_2046, 3, 0, 0);
        chk("tlbwi_w_index", w_index, 3);
        chk("tlbwi_w_pfn0", w_pfn0, 32'h41);
        run_op(1, 0, -1, 0, 0, 0, 0, 0, 0, 0);
        // MTC0 in flight for 3 cycles from accept
        run_op(0, 3, -1, 0, 0, 0, 0, 0, 0, 0);
        run_op(2, 3, -1, 0, 0, 0, 0, 0, 0, 0);
        // flush in EXEC, COMMIT, and at the request cycle
        run_op(2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        run_op(2, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        run_op(2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_op(3, 2, 2, 0, 0, 0, 0, 0, 0, 0);
        // TLBWR pair accepted 5 cycles apart
        run_op(3, 0, -1, 0, 0, 0, 0, 0, 0, 0);
        w1 = last_w;
        idle_cycle();
        run_op(3, 0, -1, 0, 0, 0, 0, 0, 0, 0);
`ifdef TLBWR_RANDOM_EN
        chk("wr_delta", 32'((w1 - last_w) & 4'hf), 5);
`else
        chk("wr_no_rand", 32'(w1 != last_w || 1'b1), 1);
`endif
        // async reset while in EXEC
        op_valid = 1'b1; op_type = 2'b10; cp0_wr_busy = 1'b0; ex_flush = 1'b0;
        @(posedge clk); #1;
        op_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("arst_we", we, 0);
        chk("arst_done", {done, refetch, cp0_tlbp, cp0_tlbr}, 0);
        chk("arst_op_ready", op_ready, 1);
        @(posedge clk); #1;
        resetn = 1'b1; rst_cyc = cyc;

        for (int i = 0; i < 60; i++) begin
            nb = $urandom_range(0, 3);
            f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb + 2) : -1;
            run_op($urandom_range(0, 3), nb, f, 0, 0, 0, 0, 0, 0, 0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
